stick_frame_sched: RTL and testbench

STICK_FRAME_SCHED -- requirements
Module: stick_frame_sched

---
 rtl/stick_frame_sched_if.sv | 31 +++
 rtl/stick_frame_sched.sv | 151 +++++++++++++++
 tb/tb_stick_frame_sched.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stick_frame_sched_if.sv
// Capture-buffer and transmit-stream signals of the stick frame scheduler.
// The master side is the scheduler; the slave side is the buffer plus transmit sink.
interface stick_frame_sched_if;
    logic       acq_en;
    logic [7:0] acq_addr;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx_vld;
    logic       tx_rdy;
    logic [7:0] tx_data;

    modport master (
        output acq_en,
        output acq_addr,
        output rd_addr,
        output tx_vld,
        output tx_data,
        input  rd_data,
        input  tx_rdy
    );

    modport slave (
        input  acq_en,
        input  acq_addr,
        input  rd_addr,
        input  tx_vld,
        input  tx_data,
        output rd_data,
        output tx_rdy
    );
endinterface

// File: rtl/stick_frame_sched.sv
// Frame scheduler: on each external sync, pulse the probe, wait, capture a block of samples,
// then stream a frame-count header followed by the captured samples.
module stick_frame_sched #(
    parameter int unsigned PULSE_LEN = 16,
    parameter int unsigned DELAY_LEN = 64,
    parameter int unsigned ACQ_LEN   = 256
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   i_sync,
    output logic                   o_pulse,
    output logic                   o_busy,
    output logic [7:0]             o_ovr_cnt,
    stick_frame_sched_if.master    bus_io
);

    localparam logic [15:0] PulseLast = 16'(PULSE_LEN - 1);
    localparam logic [15:0] DelayLast = 16'(DELAY_LEN - 1);
    localparam logic [7:0]  AcqLast   = 8'(ACQ_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPulse,
        StDelay,
        StAcq,
        StSendHdr,
        StSendData
    } state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [7:0]  idx_q;
    logic [7:0]  frame_cnt_q;
    logic [7:0]  ovr_cnt_q;
    logic        sync1_q, sync2_q, sync3_q;
    logic [1:0]  fill_q;
    logic        armed_q;
    logic        pulse_q, acq_en_q, tx_vld_q;
    logic        rise;

    // armed_q blocks a level already high at reset release from looking like a fresh edge
    assign rise = sync2_q & ~sync3_q & armed_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            ovr_cnt_q   <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            pulse_q     <= 1'b0;
            acq_en_q    <= 1'b0;
            tx_vld_q    <= 1'b0;
        end else begin
            sync1_q <= i_sync;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && !sync2_q) begin
                armed_q <= 1'b1;
            end
            if (rise && (state_q != StIdle) && (ovr_cnt_q != 8'hFF)) begin
                ovr_cnt_q <= ovr_cnt_q + 8'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_q <= StPulse;
                        pulse_q <= 1'b1;
                        cnt_q   <= PulseLast;
                    end
                end
                StPulse: begin
                    if (cnt_q == 16'd0) begin
                        pulse_q <= 1'b0;
                        if (DELAY_LEN == 0) begin
                            state_q  <= StAcq;
                            acq_en_q <= 1'b1;
                        end else begin
                            state_q <= StDelay;
                            cnt_q   <= DelayLast;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                StDelay: begin
                    if (cnt_q == 16'd0) begin
                        state_q  <= StAcq;
                        acq_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                // cnt counts up from 0 here and doubles as the write address
                StAcq: begin
                    if (cnt_q == {8'd0, AcqLast}) begin
                        state_q  <= StSendHdr;
                        acq_en_q <= 1'b0;
                        tx_vld_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StSendHdr: begin
                    if (bus_io.tx_rdy) begin
                        state_q <= StSendData;
                    end
                end
                StSendData: begin
                    if (bus_io.tx_rdy) begin
                        if (idx_q == AcqLast) begin
                            state_q     <= StIdle;
                            tx_vld_q    <= 1'b0;
                            idx_q       <= '0;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_pulse         = pulse_q;
    assign o_busy          = (state_q != StIdle);
    assign o_ovr_cnt       = ovr_cnt_q;
    assign bus_io.acq_en   = acq_en_q;
    assign bus_io.acq_addr = acq_en_q ? cnt_q[7:0] : 8'd0;
    assign bus_io.rd_addr  = idx_q;
    assign bus_io.tx_vld   = tx_vld_q;

    always_comb begin
        bus_io.tx_data = 8'd0;
        if (state_q == StSendHdr) begin
            bus_io.tx_data = frame_cnt_q;
        end else if (state_q == StSendData) begin
            bus_io.tx_data = bus_io.rd_data;
        end
    end

endmodule

// File: tb/tb_stick_frame_sched.sv
// Scoreboard bench: a default-parameter instance and a short-frame instance (no delay, one sample).
module tb_stick_frame_sched;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [1:0] sync_i;
  logic [1:0] rdy_r;
  logic       pulse_a, pulse_b, busy_a, busy_b;
  logic [7:0] ovr_a, ovr_b;

  logic [1:0] pulse_w, busy_w, acq_w, vld_w;
  logic [7:0] ovr_w[2], aaddr_w[2], raddr_w[2], data_w[2];
  logic [7:0] mem0[256];
  logic [7:0] mem1[256];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] seed_r[2];
  logic [7:0] fc[2];
  int         pcnt[2], gcnt[2], acnt[2], words[2];
  logic [1:0] pulse_p, busy_p, acq_p, vld_p, rdy_p;
  logic [7:0] data_p[2], raddr_p[2];
  bit         abort;
  int         rdy_mode;
  int         n_tests, n_fail;

  always #5 sys_clk = ~sys_clk;

  stick_frame_sched_if bus_a ();
  stick_frame_sched_if bus_b ();

  stick_frame_sched u_dut_a (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .i_sync    (sync_i[0]),
    .o_pulse   (pulse_a),
    .o_busy    (busy_a),
    .o_ovr_cnt (ovr_a),
    .bus_io    (bus_a)
  );

  stick_frame_sched #(
    .PULSE_LEN (2),
    .DELAY_LEN (0),
    .ACQ_LEN   (1)
  ) u_dut_b (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .i_sync    (sync_i[1]),
    .o_pulse   (pulse_b),
    .o_busy    (busy_b),
    .o_ovr_cnt (ovr_b),
    .bus_io    (bus_b)
  );

  assign bus_a.rd_data = mem0[bus_a.rd_addr];
  assign bus_b.rd_data = mem1[bus_b.rd_addr];
  assign bus_a.tx_rdy  = rdy_r[0];
  assign bus_b.tx_rdy  = rdy_r[1];

  assign pulse_w    = {pulse_b, pulse_a};
  assign busy_w     = {busy_b, busy_a};
  assign acq_w      = {bus_b.acq_en, bus_a.acq_en};
  assign vld_w      = {bus_b.tx_vld, bus_a.tx_vld};
  assign ovr_w[0]   = ovr_a;
  assign ovr_w[1]   = ovr_b;
  assign aaddr_w[0] = bus_a.acq_addr;
  assign aaddr_w[1] = bus_b.acq_addr;
  assign raddr_w[0] = bus_a.rd_addr;
  assign raddr_w[1] = bus_b.rd_addr;
  assign data_w[0]  = bus_a.tx_data;
  assign data_w[1]  = bus_b.tx_data;

  function automatic int plen(input int d);
    return (d == 0) ? 16 : 2;
  endfunction

  function automatic int dlen(input int d);
    return (d == 0) ? 64 : 0;
  endfunction

  function automatic int alen(input int d);
    return (d == 0) ? 256 : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_state();
    for (int d = 0; d < 2; d++) begin
      pcnt[d]    = 0;
      gcnt[d]    = 0;
      acnt[d]    = 0;
      words[d]   = 0;
      fc[d]      = 8'd0;
      seed_r[d]  = 8'd0;
      data_p[d]  = 8'd0;
      raddr_p[d] = 8'd0;
    end
    pulse_p = '0;
    busy_p  = '0;
    acq_p   = '0;
    vld_p   = '0;
    rdy_p   = '0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic exp_push(input int d, input logic [7:0] v);
    if (d == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  // Per-cycle observation of one instance: timing, capture, stream hold and scoreboard.
  task automatic mon(input int d);
    logic [7:0] v;
    int         sz;
    check_eq("one_hot", 32'($countones({pulse_w[d], acq_w[d], vld_w[d]}) <= 1), 32'd1);
    if (pulse_w[d]) begin
      pcnt[d]++;
    end else if (pulse_p[d]) begin
      check_eq("pulse_len", pcnt[d], plen(d));
      if (dlen(d) == 0) check_eq("acq_after_pulse", 32'(acq_w[d]), 32'd1);
      pcnt[d] = 0;
    end
    if (busy_w[d] && !pulse_w[d] && !acq_w[d] && !vld_w[d]) gcnt[d]++;
    if (acq_w[d]) begin
      if (!acq_p[d]) begin
        check_eq("delay_len", gcnt[d], dlen(d));
        gcnt[d] = 0;
      end
      check_eq("acq_addr", 32'(aaddr_w[d]), acnt[d]);
      v = aaddr_w[d] ^ seed_r[d];
      if (d == 0) mem0[aaddr_w[d]] <= v;
      else mem1[aaddr_w[d]] <= v;
      exp_push(d, v);
      acnt[d]++;
    end else begin
      if (acq_p[d]) check_eq("acq_len", acnt[d], alen(d));
      acnt[d] = 0;
      check_eq("acq_addr_idle", 32'(aaddr_w[d]), 32'd0);
    end
    if (vld_p[d] && !rdy_p[d]) begin
      check_eq("hold_vld", 32'(vld_w[d]), 32'd1);
      check_eq("hold_data", 32'(data_w[d]), 32'(data_p[d]));
      check_eq("hold_rd_addr", 32'(raddr_w[d]), 32'(raddr_p[d]));
    end
    if (!vld_w[d]) check_eq("tx_data_idle", 32'(data_w[d]), 32'd0);
    if (vld_w[d] && rdy_r[d]) begin
      check_eq("rd_addr", 32'(raddr_w[d]), (words[d] == 0) ? 0 : words[d] - 1);
      sz = (d == 0) ? exp_q0.size() : exp_q1.size();
      check_eq("sb_nonempty", 32'(sz > 0), 32'd1);
      if (sz > 0) begin
        if (d == 0) v = exp_q0.pop_front();
        else v = exp_q1.pop_front();
        check_eq((d == 0) ? "word_a" : "word_b", 32'(data_w[d]), 32'(v));
      end
      words[d]++;
    end
    if (busy_p[d] && !busy_w[d]) begin
      check_eq("frame_words", words[d], alen(d) + 1);
      words[d] = 0;
    end
    pulse_p[d] = pulse_w[d];
    busy_p[d]  = busy_w[d];
    acq_p[d]   = acq_w[d];
    vld_p[d]   = vld_w[d];
    rdy_p[d]   = rdy_r[d];
    data_p[d]  = data_w[d];
    raddr_p[d] = raddr_w[d];
  endtask

  always @(negedge sys_clk) begin
    if (rst_n === 1'b1 && !abort) begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  // Sink ready: 0 = always ready, 1 = repeating 1,0,0,1, 2 = stalled.
  initial begin
    logic [3:0] pat;
    int         ph;
    pat   = 4'b1001;
    ph    = 0;
    rdy_r = 2'b11;
    forever begin
      @(posedge sys_clk);
      #1;
      case (rdy_mode)
        1: begin
          rdy_r[0] = pat[ph];
          ph = (ph + 1) % 4;
        end
        2:       rdy_r[0] = 1'b0;
        default: rdy_r[0] = 1'b1;
      endcase
    end
  end

  function automatic bit cond(input int d, input int which);
    case (which)
      0:       return !busy_w[d];
      1:       return acq_w[d];
      2:       return vld_w[d];
      default: return words[d] >= 100;
    endcase
  endfunction

  task automatic wait_until(input int d, input int which, input string tag, input int budget);
    int n = 0;
    while (!cond(d, which) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq(tag, 32'(cond(d, which)), 32'd1);
  endtask

  task automatic sync_pulse(input int d, input int hi, input int lo);
    @(negedge sys_clk);
    sync_i[d] = 1'b1;
    repeat (hi) @(negedge sys_clk);
    sync_i[d] = 1'b0;
    repeat (lo) @(negedge sys_clk);
  endtask

  // Queue the expected header, raise sync, and measure the latency to the pulse.
  task automatic start_frame(input int d, input logic [7:0] seed, input int hi);
    int lat = 0;
    seed_r[d] = seed;
    exp_push(d, fc[d]);
    fc[d] = fc[d] + 8'd1;
    @(negedge sys_clk);
    sync_i[d] = 1'b1;
    while (!busy_w[d] && lat < 10) begin
      @(posedge sys_clk);
      #1;
      lat++;
    end
    check_eq("sync_to_pulse", lat, 3);
    check_eq("pulse_at_start", 32'(pulse_w[d]), 32'd1);
    repeat (hi - lat) @(negedge sys_clk);
    sync_i[d] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pulse"}, 32'(pulse_a), 32'd0);
    check_eq({tag, "_acq_en"}, 32'(bus_a.acq_en), 32'd0);
    check_eq({tag, "_acq_addr"}, 32'(bus_a.acq_addr), 32'd0);
    check_eq({tag, "_rd_addr"}, 32'(bus_a.rd_addr), 32'd0);
    check_eq({tag, "_tx_vld"}, 32'(bus_a.tx_vld), 32'd0);
    check_eq({tag, "_tx_data"}, 32'(bus_a.tx_data), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_a), 32'd0);
    check_eq({tag, "_ovr"}, 32'(ovr_a), 32'd0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    sync_i   = 2'b00;
    rdy_mode = 0;
    abort    = 1'b0;
    clear_state();
    repeat (3) @(negedge sys_clk);
    check_all_zero("rst");
    check_eq("rst_busy_b", 32'(busy_b), 32'd0);
    check_eq("rst_ovr_b", 32'(ovr_b), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    // Default frame, sink always ready, 200 ns sync
    start_frame(0, 8'h5A, 20);
    wait_until(0, 0, "a1_done", 1000);

    // Back-to-back frame with a stuttering sink and three syncs during capture
    rdy_mode = 1;
    start_frame(0, 8'hC3, 20);
    wait_until(0, 1, "a2_acq", 200);
    repeat (3) sync_pulse(0, 3, 3);
    wait_until(0, 0, "a2_done", 2000);
    check_eq("ovr_three", 32'(ovr_w[0]), 32'd3);

    // Stalled header while 300 syncs arrive
    rdy_mode = 2;
    start_frame(0, 8'h0F, 20);
    wait_until(0, 2, "a3_hdr", 500);
    repeat (300) sync_pulse(0, 2, 2);
    check_eq("ovr_sat", 32'(ovr_w[0]), 32'd255);
    check_eq("hdr_held", 32'(data_w[0]), 32'd2);
    rdy_mode = 0;
    wait_until(0, 0, "a3_done", 1000);

    // Abort mid-stream with sync held high through reset release
    start_frame(0, 8'h33, 20);
    wait_until(0, 3, "a4_mid", 1000);
    @(posedge sys_clk);
    #2;
    sync_i[0] = 1'b1;
    abort     = 1'b1;
    rst_n     = 1'b0;
    #1;
    check_all_zero("abort");
    clear_state();
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    abort = 1'b0;
    repeat (10) @(negedge sys_clk);
    check_eq("no_rise_after_rst", 32'(busy_w[0]), 32'd0);
    sync_i[0] = 1'b0;
    repeat (4) @(negedge sys_clk);
    start_frame(0, 8'h99, 20);
    wait_until(0, 0, "a5_done", 1000);

    // Short instance: 257 frames so the header walks 0..255 and wraps to 0
    for (int i = 0; i < 257; i++) begin
      start_frame(1, 8'(i * 3 + 1), 3);
      wait_until(1, 0, "b_done", 40);
      repeat (2) @(negedge sys_clk);
    end
    check_eq("b_ovr_none", 32'(ovr_w[1]), 32'd0);
    check_eq("b_next_hdr", 32'(fc[1]), 32'd1);
    check_eq("sb_drain_a", exp_q0.size(), 0);
    check_eq("sb_drain_b", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
